key_sched_ctrl: RTL and testbench

- Sequencer for the AES-128 key_expansion datapath. Its registered K*_new outputs feed back to the K* inputs, except on the load cycle.
- Drives round_number, bypass and enable_key_expansion so the external key register steps from the cipher key (round 0) through round key ROUNDS, one round per accepted handshake.
- Exposes valid/ready tracking of which round key the key register currently holds, so the cipher round controller consumes each key exactly once.

---
 rtl/key_sched_if.sv | 23 ++
 rtl/key_sched_ctrl.sv | 108 ++++++++++
 tb/tb_key_sched_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/key_sched_if.sv
// Handshake/control bundle between the key-schedule sequencer and its user.
interface key_sched_if #(parameter int RW = 4);
  logic          start;
  logic          abort;
  logic          key_ready;
  logic [RW-1:0] round_number;
  logic          bypass;
  logic          enable_key_expansion;
  logic          key_valid;
  logic [RW-1:0] key_round;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, key_ready,
    input  round_number, bypass, enable_key_expansion, key_valid, key_round, busy, done
  );

  modport slave (
    input  start, abort, key_ready,
    output round_number, bypass, enable_key_expansion, key_valid, key_round, busy, done
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// Sequencer stepping an external AES-128 key register from the cipher key
// through round key ROUNDS, one expansion per accepted key_ready handshake.
module key_sched_ctrl #(
  parameter int ROUNDS = 10,
  parameter int RW     = 4
) (
  input  logic           clk,
  input  logic           rst,
  key_sched_if.slave     bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] EXPAND = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [RW-1:0] LAST = RW'(ROUNDS);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [RW-1:0] key_round_q, key_round_d;
  logic          key_valid_q, key_valid_d;
  logic          bypass_q, bypass_d;
  logic          done_q, done_d;
  logic          step;

  // One expansion step: the consumer has taken the key and nothing cancels it.
  assign step = (state_q == EXPAND) & bus.key_ready & ~bus.abort;

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    key_round_d = key_round_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        state_d     = EXPAND;
        rnd_d       = RW'(1);
        key_valid_d = 1'b1;
        key_round_d = '0;
      end
      EXPAND: begin
        if (step) begin
          key_round_d = rnd_q;
          if (rnd_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rnd_d = rnd_q + RW'(1);
          end
        end
      end
      DONE: begin
        if (bus.key_ready) begin
          state_d     = IDLE;
          rnd_d       = '0;
          key_valid_d = 1'b0;
          key_round_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort returns to IDLE with every idle value and suppresses the done pulse.
    if (bus.abort) begin
      state_d     = IDLE;
      rnd_d       = '0;
      key_valid_d = 1'b0;
      key_round_d = '0;
      done_d      = 1'b0;
    end

    bypass_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      key_round_q <= '0;
      key_valid_q <= 1'b0;
      bypass_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      key_round_q <= key_round_d;
      key_valid_q <= key_valid_d;
      bypass_q    <= bypass_d;
      done_q      <= done_d;
    end
  end

  // rnd is 0 in IDLE/LOAD and parks at ROUNDS in DONE, so it doubles as round_number.
  assign bus.round_number         = rnd_q;
  assign bus.bypass               = bypass_q;
  assign bus.enable_key_expansion = step;
  assign bus.key_valid            = key_valid_q;
  assign bus.key_round            = key_round_q;
  assign bus.busy                 = (state_q != IDLE);
  assign bus.done                 = done_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: vector table, directed sequences and random
// traffic on a ROUNDS=10 and a ROUNDS=1 instance against a progress-count model.
module tb_key_sched_ctrl;

  typedef struct packed {
    logic       en;
    logic       byp;
    logic       kv;
    logic       busy;
    logic       dn;
    logic [3:0] rn;
    logic [3:0] kr;
  } outs_t;

  typedef struct packed {
    logic  s;
    logic  a;
    logic  r;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_sched_if #(.RW(4)) bus10 ();
  key_sched_if #(.RW(4)) bus1 ();

  key_sched_ctrl #(.ROUNDS(10), .RW(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
  key_sched_ctrl #(.ROUNDS(1),  .RW(4)) dut1  (.clk(clk), .rst(rst), .bus(bus1));

  int    n_chk  = 0;
  int    n_pass = 0;
  int    p10 = 0, p1 = 0;
  bit    dn10 = 0, dn1 = 0;
  outs_t act10, act1;
  vec_t  vecs[10];

  // Model: p counts schedule progress. 0 idle, 1 load, 2..R+1 expanding with
  // key k=p-2 held, R+2 waiting for the final key to be taken.
  function automatic outs_t model_out(input int p, input int R, input bit dn,
                                      input bit a, input bit r);
    outs_t o;
    o.busy = (p != 0);
    o.byp  = (p == 1);
    o.kv   = (p >= 2);
    o.rn   = (p <= 1) ? 4'd0 : 4'(((p - 1) > R) ? R : (p - 1));
    o.kr   = (p < 2) ? 4'd0 : 4'(p - 2);
    o.en   = (p >= 2) && (p <= R + 1) && r && !a;
    o.dn   = dn;
    return o;
  endfunction

  function automatic int model_next(input int p, input int R, input bit s,
                                    input bit a, input bit r, output bit dn);
    int np;
    dn = !a && (p == R + 1) && r;
    if (a)                np = 0;
    else if (p == 0)      np = s ? 1 : 0;
    else if (p == 1)      np = 2;
    else if (p <= R + 1)  np = r ? p + 1 : p;
    else                  np = r ? 0 : p;
    return np;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_outs(input string tag, input outs_t a, input outs_t e);
    check({tag, ".enable"},    a.en,   e.en);
    check({tag, ".bypass"},    a.byp,  e.byp);
    check({tag, ".key_valid"}, a.kv,   e.kv);
    check({tag, ".busy"},      a.busy, e.busy);
    check({tag, ".done"},      a.dn,   e.dn);
    check({tag, ".round_num"}, a.rn,   e.rn);
    check({tag, ".key_round"}, a.kr,   e.kr);
  endtask

  // One clock: drive inputs, sample outputs at negedge, advance the model at posedge.
  task automatic cyc(input bit s, input bit a, input bit r);
    bus10.start = s; bus10.abort = a; bus10.key_ready = r;
    bus1.start  = s; bus1.abort  = a; bus1.key_ready  = r;
    @(negedge clk);
    act10 = {bus10.enable_key_expansion, bus10.bypass, bus10.key_valid, bus10.busy,
             bus10.done, bus10.round_number, bus10.key_round};
    act1  = {bus1.enable_key_expansion, bus1.bypass, bus1.key_valid, bus1.busy,
             bus1.done, bus1.round_number, bus1.key_round};
    cmp_outs("m10", act10, model_out(p10, 10, dn10, a, r));
    cmp_outs("m1",  act1,  model_out(p1,  1,  dn1,  a, r));
    @(posedge clk);
    if (!rst) begin
      p10 = 0; p1 = 0; dn10 = 0; dn1 = 0;
    end else begin
      p10 = model_next(p10, 10, s, a, r, dn10);
      p1  = model_next(p1,  1,  s, a, r, dn1);
    end
    #1;
  endtask

  function automatic vec_t mk(input bit s, a, r, en, byp, kv, busy, dn,
                              input int rn, input int kr);
    vec_t v;
    v.s = s; v.a = a; v.r = r;
    v.exp = {en, byp, kv, busy, dn, 4'(rn), 4'(kr)};
    return v;
  endfunction

  initial begin
    int en1_cnt;
    int done1_at;

    //           s  a  r  en byp kv busy dn rn kr
    vecs[0] = mk(1, 0, 1, 0, 0,  0, 0,   0, 0, 0);
    vecs[1] = mk(0, 0, 1, 0, 1,  0, 1,   0, 0, 0);
    vecs[2] = mk(0, 0, 1, 1, 0,  1, 1,   0, 1, 0);
    vecs[3] = mk(0, 0, 1, 1, 0,  1, 1,   0, 2, 1);
    vecs[4] = mk(0, 0, 0, 0, 0,  1, 1,   0, 3, 2);
    vecs[5] = mk(1, 0, 0, 0, 0,  1, 1,   0, 3, 2);
    vecs[6] = mk(0, 0, 1, 1, 0,  1, 1,   0, 3, 2);
    vecs[7] = mk(0, 1, 1, 0, 0,  1, 1,   0, 4, 3);
    vecs[8] = mk(1, 1, 1, 0, 0,  0, 0,   0, 0, 0);
    vecs[9] = mk(0, 0, 1, 0, 0,  0, 0,   0, 0, 0);

    bus10.start = 0; bus10.abort = 0; bus10.key_ready = 0;
    bus1.start  = 0; bus1.abort  = 0; bus1.key_ready  = 0;
    rst = 0;
    @(posedge clk); #1;

    // Reset held with start asserted: nothing moves.
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    check("rst.busy", act10.busy, 0);
    check("rst.key_valid", act10.kv, 0);
    rst = 1;

    // Vector table, starting from IDLE right after reset release.
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].s, vecs[i].a, vecs[i].r);
      cmp_outs($sformatf("vec%0d", i), act10, vecs[i].exp);
    end

    // Free run with key_ready held: latency and single done pulse.
    en1_cnt = 0; done1_at = -1;
    for (int c = 0; c <= 13; c++) begin
      cyc(c == 0, 0, 1);
      check($sformatf("run.bypass@%0d", c), act10.byp, c == 1);
      check($sformatf("run.enable@%0d", c), act10.en, (c >= 2) && (c <= 11));
      if (c >= 2 && c <= 11) check($sformatf("run.round@%0d", c), act10.rn, c - 1);
      if (c >= 2 && c <= 12) check($sformatf("run.key_round@%0d", c), act10.kr, c - 2);
      check($sformatf("run.done@%0d", c), act10.dn, c == 12);
      if (act1.en) en1_cnt++;
      if (act1.dn) done1_at = c;
    end
    check("run.idle_at_13", act10.busy, 0);
    check("r1.enable_cycles", en1_cnt, 1);
    check("r1.done_cycle", done1_at, 3);

    // Stall at key_round 4, then a stalled final handshake with start pokes.
    cyc(1, 0, 1);
    for (int c = 1; c <= 5; c++) cyc(0, 0, 1);
    for (int c = 6; c <= 8; c++) begin
      cyc(0, 0, 0);
      check("stall.enable", act10.en, 0);
      check("stall.round", act10.rn, 5);
      check("stall.key_round", act10.kr, 4);
    end
    cyc(0, 0, 1);
    check("stall.resume_en", act10.en, 1);
    cyc(0, 0, 1);
    check("stall.key_round5", act10.kr, 5);
    for (int c = 11; c <= 14; c++) cyc(0, 0, 1);
    for (int c = 15; c <= 19; c++) begin
      cyc(c > 15, 0, 0);
      check("fin.key_valid", act10.kv, 1);
      check("fin.key_round", act10.kr, 10);
      check("fin.round", act10.rn, 10);
      check($sformatf("fin.done@%0d", c), act10.dn, c == 15);
    end
    cyc(1, 0, 1);
    check("fin.busy_still", act10.busy, 1);
    cyc(0, 0, 1);
    check("fin.idle", act10.busy, 0);
    check("fin.kv_low", act10.kv, 0);

    // Abort at key_round 6 with key_ready high, then a fresh start.
    cyc(1, 0, 1);
    for (int c = 1; c <= 7; c++) cyc(0, 0, 1);
    cyc(0, 1, 1);
    check("abort.key_round", act10.kr, 6);
    check("abort.enable", act10.en, 0);
    cyc(0, 0, 1);
    check("abort.idle", act10.busy, 0);
    check("abort.kv", act10.kv, 0);
    check("abort.no_done", act10.dn, 0);
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    check("restart.bypass", act10.byp, 1);
    cyc(0, 0, 1);
    check("restart.key_round", act10.kr, 0);
    check("restart.round", act10.rn, 1);

    // Random traffic, occasional resets; model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
    end
    rst = 1;
    cyc(0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
